frontend_sweep_controller: RTL and testbench

Sequencer that drives the phase-increment input of the ADC/DAC sensor frontend through a programmable frequency sweep. At each point it waits for a settling time, samples the filtered SIN/COS mul-acc outputs and computes an |I|+|Q| magnitude. It tracks the point with maximum response and, on completion, parks the oscillator at that phase increment. The block sits between the control registers and the frontend's `PHASE_INCREMENT_IN`; it is used for resonance search at power-up and on demand.

---
 rtl/frontend_sweep_controller.sv | 197 +++++++++++++++++++
 tb/tb_frontend_sweep_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frontend_sweep_controller.sv
// Frequency-sweep sequencer for the sensor frontend: steps the phase increment, measures |I|+|Q|,
// and parks on the strongest point. Define SWEEP_POINT_STREAM_EN to expose per-point results.
module frontend_sweep_controller #(
    parameter int unsigned PHASE_INCREMENT_BITS = 28,
    parameter int unsigned MUL_ACC_WIDTH        = 32,
    parameter int unsigned POINT_COUNT_BITS     = 10,
    parameter int unsigned SETTLE_BITS          = 16
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              CE,
    input  logic                              START,
    input  logic                              ABORT,
    input  logic [PHASE_INCREMENT_BITS-1:0]   SWEEP_START_INC,
    input  logic [PHASE_INCREMENT_BITS-1:0]   SWEEP_STEP_INC,
    input  logic [POINT_COUNT_BITS-1:0]       SWEEP_POINTS,
    input  logic [SETTLE_BITS-1:0]            SETTLE_CYCLES,
    input  logic signed [MUL_ACC_WIDTH-1:0]   SIN_MUL_ACC,
    input  logic signed [MUL_ACC_WIDTH-1:0]   COS_MUL_ACC,
    output logic [PHASE_INCREMENT_BITS-1:0]   PHASE_INCREMENT_OUT,
    output logic                              BUSY,
    output logic                              DONE,
    output logic [PHASE_INCREMENT_BITS-1:0]   BEST_PHASE_INCREMENT,
    output logic [MUL_ACC_WIDTH:0]            BEST_MAGNITUDE
`ifdef SWEEP_POINT_STREAM_EN
    ,
    output logic                              POINT_VALID,
    output logic [POINT_COUNT_BITS-1:0]       POINT_INDEX,
    output logic [MUL_ACC_WIDTH:0]            POINT_MAGNITUDE
`endif
);

    localparam logic [POINT_COUNT_BITS-1:0] PointOne  = POINT_COUNT_BITS'(1);
    localparam logic [SETTLE_BITS-1:0]      SettleOne = SETTLE_BITS'(1);
    localparam logic [MUL_ACC_WIDTH-1:0]    MaOne     = MUL_ACC_WIDTH'(1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StMeasure,
        StCompare,
        StFinish
    } state_e;

    state_e                          state_q;

    // Sweep parameters captured on the accepting edge
    logic [PHASE_INCREMENT_BITS-1:0] start_inc_q;
    logic [PHASE_INCREMENT_BITS-1:0] step_q;
    logic [POINT_COUNT_BITS-1:0]     last_idx_q;
    logic [SETTLE_BITS-1:0]          settle_last_q;

    logic [POINT_COUNT_BITS-1:0]     idx_q;
    logic [SETTLE_BITS-1:0]          settle_cnt_q;
    logic [MUL_ACC_WIDTH-1:0]        abs_sin_q;
    logic [MUL_ACC_WIDTH-1:0]        abs_cos_q;
    logic [PHASE_INCREMENT_BITS-1:0] work_inc_q;
    logic [MUL_ACC_WIDTH:0]          work_mag_q;

    logic [PHASE_INCREMENT_BITS-1:0] phase_q;
    logic [PHASE_INCREMENT_BITS-1:0] best_inc_q;
    logic [MUL_ACC_WIDTH:0]          best_mag_q;
    logic                            done_q;

`ifdef SWEEP_POINT_STREAM_EN
    logic                            point_pend_q;
    logic                            point_valid_q;
    logic [POINT_COUNT_BITS-1:0]     point_idx_q;
    logic [MUL_ACC_WIDTH:0]          point_mag_q;
`endif

    logic [MUL_ACC_WIDTH-1:0]        sin_u;
    logic [MUL_ACC_WIDTH-1:0]        cos_u;
    logic [MUL_ACC_WIDTH-1:0]        abs_sin;
    logic [MUL_ACC_WIDTH-1:0]        abs_cos;
    logic [MUL_ACC_WIDTH:0]          mag;

    // Two's-complement negate without saturation: the most negative input maps to 2^(W-1)
    always_comb begin
        sin_u   = SIN_MUL_ACC;
        cos_u   = COS_MUL_ACC;
        abs_sin = sin_u[MUL_ACC_WIDTH-1] ? (~sin_u + MaOne) : sin_u;
        abs_cos = cos_u[MUL_ACC_WIDTH-1] ? (~cos_u + MaOne) : cos_u;
        mag     = {1'b0, abs_sin_q} + {1'b0, abs_cos_q};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= StIdle;
            start_inc_q   <= '0;
            step_q        <= '0;
            last_idx_q    <= '0;
            settle_last_q <= '0;
            idx_q         <= '0;
            settle_cnt_q  <= '0;
            abs_sin_q     <= '0;
            abs_cos_q     <= '0;
            work_inc_q    <= '0;
            work_mag_q    <= '0;
            phase_q       <= '0;
            best_inc_q    <= '0;
            best_mag_q    <= '0;
            done_q        <= 1'b0;
`ifdef SWEEP_POINT_STREAM_EN
            point_pend_q  <= 1'b0;
            point_valid_q <= 1'b0;
            point_idx_q   <= '0;
            point_mag_q   <= '0;
`endif
        end else if (CE) begin
            done_q <= 1'b0;
`ifdef SWEEP_POINT_STREAM_EN
            point_valid_q <= point_pend_q;
            point_pend_q  <= 1'b0;
`endif
            if (state_q != StIdle && ABORT) begin
                // Abort leaves the oscillator and published results untouched
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (START && !ABORT) begin
                            start_inc_q   <= SWEEP_START_INC;
                            step_q        <= SWEEP_STEP_INC;
                            last_idx_q    <= (SWEEP_POINTS == '0) ? '0 : SWEEP_POINTS - PointOne;
                            settle_last_q <= (SETTLE_CYCLES == '0) ? '0
                                                                    : SETTLE_CYCLES - SettleOne;
                            state_q       <= StLoad;
                        end
                    end
                    StLoad: begin
                        phase_q      <= start_inc_q;
                        work_inc_q   <= start_inc_q;
                        work_mag_q   <= '0;
                        idx_q        <= '0;
                        settle_cnt_q <= '0;
                        state_q      <= StSettle;
                    end
                    StSettle: begin
                        if (settle_cnt_q == settle_last_q) begin
                            state_q <= StMeasure;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + SettleOne;
                        end
                    end
                    StMeasure: begin
                        abs_sin_q <= abs_sin;
                        abs_cos_q <= abs_cos;
                        state_q   <= StCompare;
                    end
                    StCompare: begin
                        // Strict compare so ties keep the earlier point
                        if (mag > work_mag_q) begin
                            work_mag_q <= mag;
                            work_inc_q <= phase_q;
                        end
`ifdef SWEEP_POINT_STREAM_EN
                        point_pend_q <= 1'b1;
                        point_idx_q  <= idx_q;
                        point_mag_q  <= mag;
`endif
                        if (idx_q == last_idx_q) begin
                            state_q <= StFinish;
                        end else begin
                            idx_q        <= idx_q + PointOne;
                            phase_q      <= phase_q + step_q;
                            settle_cnt_q <= '0;
                            state_q      <= StSettle;
                        end
                    end
                    StFinish: begin
                        best_inc_q <= work_inc_q;
                        best_mag_q <= work_mag_q;
                        phase_q    <= work_inc_q;
                        done_q     <= 1'b1;
                        state_q    <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign PHASE_INCREMENT_OUT  = phase_q;
    assign BUSY                 = (state_q != StIdle);
    assign DONE                 = done_q;
    assign BEST_PHASE_INCREMENT = best_inc_q;
    assign BEST_MAGNITUDE       = best_mag_q;

`ifdef SWEEP_POINT_STREAM_EN
    assign POINT_VALID     = point_valid_q;
    assign POINT_INDEX     = point_idx_q;
    assign POINT_MAGNITUDE = point_mag_q;
`endif

endmodule

// File: tb/tb_frontend_sweep_controller.sv
// Scoreboard bench for frontend_sweep_controller: stimulus pushes expected sweep results,
// a DONE monitor pops and compares them.
module tb_frontend_sweep_controller;

    logic                CLK;
    logic                RESET;
    logic                CE;
    logic                START;
    logic                ABORT;
    logic [27:0]         SWEEP_START_INC;
    logic [27:0]         SWEEP_STEP_INC;
    logic [9:0]          SWEEP_POINTS;
    logic [15:0]         SETTLE_CYCLES;
    logic signed [31:0]  SIN_MUL_ACC;
    logic signed [31:0]  COS_MUL_ACC;
    logic [27:0]         PHASE_INCREMENT_OUT;
    logic                BUSY;
    logic                DONE;
    logic [27:0]         BEST_PHASE_INCREMENT;
    logic [32:0]         BEST_MAGNITUDE;
`ifdef SWEEP_POINT_STREAM_EN
    logic                POINT_VALID;
    logic [9:0]          POINT_INDEX;
    logic [32:0]         POINT_MAGNITUDE;
`endif

    frontend_sweep_controller dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .CE                  (CE),
        .START               (START),
        .ABORT               (ABORT),
        .SWEEP_START_INC     (SWEEP_START_INC),
        .SWEEP_STEP_INC      (SWEEP_STEP_INC),
        .SWEEP_POINTS        (SWEEP_POINTS),
        .SETTLE_CYCLES       (SETTLE_CYCLES),
        .SIN_MUL_ACC         (SIN_MUL_ACC),
        .COS_MUL_ACC         (COS_MUL_ACC),
        .PHASE_INCREMENT_OUT (PHASE_INCREMENT_OUT),
        .BUSY                (BUSY),
        .DONE                (DONE),
        .BEST_PHASE_INCREMENT(BEST_PHASE_INCREMENT),
        .BEST_MAGNITUDE      (BEST_MAGNITUDE)
`ifdef SWEEP_POINT_STREAM_EN
        ,
        .POINT_VALID         (POINT_VALID),
        .POINT_INDEX         (POINT_INDEX),
        .POINT_MAGNITUDE     (POINT_MAGNITUDE)
`endif
    );

    typedef struct {
        logic [27:0] inc;
        logic [32:0] mag;
        int unsigned lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned edge_cnt = 0;
    int unsigned accept_edge = 0;
    int unsigned done_count = 0;
    logic        done_prev = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    // Frontend model: response as a function of the driven increment
    always_comb begin
        SIN_MUL_ACC = 32'sd0;
        COS_MUL_ACC = 32'sd0;
        case (PHASE_INCREMENT_OUT)
            28'd1000:     begin SIN_MUL_ACC = 32'sd3;        COS_MUL_ACC = -32'sd2;      end
            28'd1100:     begin SIN_MUL_ACC = -32'sd15;      COS_MUL_ACC = 32'sd5;       end
            28'd1200:     begin SIN_MUL_ACC = 32'sd10;       COS_MUL_ACC = -32'sd10;     end
            28'd1300:     begin SIN_MUL_ACC = -32'sd7;       COS_MUL_ACC = 32'sd0;       end
            28'd5000:     begin SIN_MUL_ACC = 32'sd1;        COS_MUL_ACC = 32'sd1;       end
            28'd5100:     begin SIN_MUL_ACC = 32'h8000_0000; COS_MUL_ACC = 32'h8000_0000; end
            28'd5200:     begin SIN_MUL_ACC = -32'sd100;     COS_MUL_ACC = 32'sd100;     end
            28'hFFFFFF0:  begin SIN_MUL_ACC = 32'sd4;        COS_MUL_ACC = 32'sd0;       end
            28'h0000010:  begin SIN_MUL_ACC = 32'sd0;        COS_MUL_ACC = -32'sd9;      end
            default:      begin SIN_MUL_ACC = 32'sd0;        COS_MUL_ACC = 32'sd0;       end
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RESET && DONE && !done_prev) begin
            done_count++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done actual=1 expected=0 t=%0t", $time);
            end else begin
                e = sb.pop_front();
                chk("best_inc", 64'(BEST_PHASE_INCREMENT), 64'(e.inc));
                chk("best_mag", 64'(BEST_MAGNITUDE), 64'(e.mag));
                chk("phase_out_parked", 64'(PHASE_INCREMENT_OUT), 64'(e.inc));
                chk("done_latency", 64'(edge_cnt - accept_edge), 64'(e.lat));
                chk("busy_at_done", 64'(BUSY), 64'd0);
            end
        end
        done_prev = DONE;
    end

    // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge
    task automatic issue(input logic [27:0] s, input logic [27:0] st, input logic [9:0] n,
                         input logic [15:0] sc, input logic [27:0] einc,
                         input logic [32:0] emag, input int unsigned elat);
        exp_t e;
        e.inc = einc;
        e.mag = emag;
        e.lat = elat;
        sb.push_back(e);
        SWEEP_START_INC = s;
        SWEEP_STEP_INC  = st;
        SWEEP_POINTS    = n;
        SETTLE_CYCLES   = sc;
        START           = 1'b1;
        @(negedge CLK);
        START       = 1'b0;
        accept_edge = edge_cnt;
        // Post-accept changes must not affect the running sweep
        SWEEP_START_INC = 28'h0ABCDEF;
        SWEEP_STEP_INC  = 28'd3;
        SWEEP_POINTS    = 10'd9;
        SETTLE_CYCLES   = 16'd50;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge CLK);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sweep_timeout actual=pending expected=done t=%0t", $time);
            sb.delete();
        end
        @(negedge CLK);
    endtask

    initial begin
        int unsigned dc;
        RESET = 1'b1;
        CE = 1'b1;
        START = 1'b0;
        ABORT = 1'b0;
        SWEEP_START_INC = '0;
        SWEEP_STEP_INC = '0;
        SWEEP_POINTS = '0;
        SETTLE_CYCLES = '0;
        repeat (3) @(negedge CLK);
        chk("rst_phase", 64'(PHASE_INCREMENT_OUT), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_done", 64'(DONE), 64'd0);
        chk("rst_best_inc", 64'(BEST_PHASE_INCREMENT), 64'd0);
        chk("rst_best_mag", 64'(BEST_MAGNITUDE), 64'd0);
        RESET = 1'b0;
        @(negedge CLK);

        // Basic sweep: magnitudes 5,20,20,7; tie keeps 1100; latency 4*(3+2)+2
        issue(28'd1000, 28'd100, 10'd4, 16'd3, 28'd1100, 33'd20, 22);
        chk("busy_after_accept", 64'(BUSY), 64'd1);
        @(negedge CLK);
        chk("load_first_inc", 64'(PHASE_INCREMENT_OUT), 64'd1000);
        wait_done();

        // Abort at the second point of a new sweep
        issue(28'd5000, 28'd100, 10'd3, 16'd2, 28'd0, 33'd0, 0);
        for (int i = 0; i < 100 && PHASE_INCREMENT_OUT != 28'd5100; i++) @(negedge CLK);
        chk("abort_reached_pt2", 64'(PHASE_INCREMENT_OUT), 64'd5100);
        void'(sb.pop_back());
        dc = done_count;
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        chk("abort_idle", 64'(BUSY), 64'd0);
        chk("abort_phase_hold", 64'(PHASE_INCREMENT_OUT), 64'd5100);
        repeat (20) @(negedge CLK);
        chk("abort_no_done", 64'(done_count), 64'(dc));
        chk("abort_best_inc", 64'(BEST_PHASE_INCREMENT), 64'd1100);
        chk("abort_best_mag", 64'(BEST_MAGNITUDE), 64'd20);

        // START together with ABORT in IDLE is refused
        START = 1'b1;
        ABORT = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        ABORT = 1'b0;
        chk("start_abort_idle", 64'(BUSY), 64'd0);
        @(negedge CLK);
        chk("start_abort_idle2", 64'(BUSY), 64'd0);

        // Extreme: both inputs at -2^31 give 2^32 without wrap; latency 3*(2+2)+2
        issue(28'd5000, 28'd100, 10'd3, 16'd2, 28'd5100, 33'h1_0000_0000, 14);
        wait_done();

        // Increment wraps modulo 2^28: second point is 0x10 and wins with 9
        issue(28'hFFFFFF0, 28'h20, 10'd2, 16'd1, 28'h0000010, 33'd9, 8);
        wait_done();

        // Degenerate counts: one point, one settle cycle; latency 1*(1+2)+2
        issue(28'd1200, 28'd7, 10'd0, 16'd0, 28'd1200, 33'd20, 5);
        wait_done();

        // CE held low for 5 edges mid-sweep stretches latency by 5; DONE held while CE=0
        issue(28'd1000, 28'd100, 10'd4, 16'd3, 28'd1100, 33'd20, 27);
        repeat (5) @(negedge CLK);
        CE = 1'b0;
        repeat (5) @(negedge CLK);
        CE = 1'b1;
        for (int i = 0; i < 200 && !DONE; i++) @(negedge CLK);
        chk("ce_done_seen", 64'(DONE), 64'd1);
        CE = 1'b0;
        repeat (3) @(negedge CLK);
        chk("done_hold_ce0", 64'(DONE), 64'd1);
        CE = 1'b1;
        @(negedge CLK);
        chk("done_clear_ce1", 64'(DONE), 64'd0);
        if (sb.size() != 0) sb.delete();

        // Asynchronous reset mid-SETTLE clears everything at once; no resume
        issue(28'd1000, 28'd100, 10'd4, 16'd3, 28'd1100, 33'd20, 22);
        repeat (2) @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("arst_phase", 64'(PHASE_INCREMENT_OUT), 64'd0);
        chk("arst_busy", 64'(BUSY), 64'd0);
        chk("arst_done", 64'(DONE), 64'd0);
        chk("arst_best_inc", 64'(BEST_PHASE_INCREMENT), 64'd0);
        chk("arst_best_mag", 64'(BEST_MAGNITUDE), 64'd0);
        sb.delete();
        dc = done_count;
        @(negedge CLK);
        RESET = 1'b0;
        repeat (40) @(negedge CLK);
        chk("arst_no_resume", 64'(BUSY), 64'd0);
        chk("arst_no_done", 64'(done_count), 64'(dc));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
